// File: rtl/tboard_pkg.sv
// Shared types and helpers for the tic-tac-toe board: symbols, FSM states
// and the mapping from (line, position) to a flat cell index.
package tboard_pkg;

    localparam logic SYM_X = 1'b0;
    localparam logic SYM_O = 1'b1;

    typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

    // Lines are numbered rows 0..n-1, columns n..2n-1, main diagonal 2n, anti-diagonal 2n+1.
    function automatic int line_cell(input int n, input int line, input int k);
        if (line < n)
            return line * n + k;
        else if (line < 2 * n)
            return k * n + (line - n);
        else if (line == 2 * n)
            return k * n + k;
        else
            return k * n + (n - 1 - k);
    endfunction

endpackage

// File: rtl/tboard_grid_if.sv
// Move request/ack handshake between the move-input controller and the board.
interface tboard_grid_if #(
    parameter int N = 3
) ();
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic          move_valid;
    logic [IW-1:0] move_row;
    logic [IW-1:0] move_col;
    logic          move_ready;
    logic          move_ack;
    logic          move_err;

    modport master (
        output move_valid, move_row, move_col,
        input  move_ready, move_ack, move_err
    );

    modport slave (
        input  move_valid, move_row, move_col,
        output move_ready, move_ack, move_err
    );
endinterface

// File: rtl/tboard_line_eval.sv
// Combinational check of one board line: hit when all N cells are occupied
// by the same symbol; sym is the symbol found on the line's first cell.
module tboard_line_eval
    import tboard_pkg::*;
#(
    parameter  int N  = 3,
    localparam int LW = $clog2(2 * N + 2),
    localparam int CW = $clog2(N * N)
) (
    input  logic [LW-1:0]  line_idx,
    input  logic [N*N-1:0] cell_valid,
    input  logic [N*N-1:0] cell_symbol,
    output logic           hit,
    output logic           sym
);

    logic [CW-1:0] ci;

    always_comb begin
        hit = 1'b1;
        ci  = CW'(line_cell(N, int'(line_idx), 0));
        sym = cell_symbol[ci];
        for (int k = 0; k < N; k++) begin
            ci = CW'(line_cell(N, int'(line_idx), k));
            if (!cell_valid[ci] || (cell_symbol[ci] != sym))
                hit = 1'b0;
        end
    end

endmodule

// File: rtl/tboard_grid.sv
// N x N tic-tac-toe board: cell storage, turn tracking, move legality and a
// one-line-per-cycle win scan after each accepted move.
//
// state | meaning
// IDLE  | waiting for a move request
// CHECK | scanning one line per cycle after an accepted move
// DONE  | game decided (win or draw), board frozen until cleared
module tboard_grid
    import tboard_pkg::*;
#(
    parameter int N = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           new_game,
    tboard_grid_if.slave   mv,
    output logic [N*N-1:0] cell_valid,
    output logic [N*N-1:0] cell_symbol,
    output logic           turn,
    output logic           game_over,
    output logic           winner,
    output logic           draw
);

    localparam int L  = 2 * N + 2;
    localparam int LW = $clog2(L);
    localparam int CW = $clog2(N * N);
    localparam int NW = $clog2(N * N + 1);

    state_t        state, state_nx;
    logic [LW-1:0] scan_idx;
    logic [NW-1:0] move_cnt;
    logic          ack_q, err_q;
    logic [CW-1:0] mv_idx;
    logic          in_range, accept, reject;
    logic          line_hit, line_sym, last_line, board_full;

    tboard_line_eval #(.N(N)) u_line_eval (
        .line_idx    (scan_idx),
        .cell_valid  (cell_valid),
        .cell_symbol (cell_symbol),
        .hit         (line_hit),
        .sym         (line_sym)
    );

    always_ff @(posedge clk) begin
        if (!reset || new_game)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        accept     = 1'b0;
        reject     = 1'b0;
        in_range   = (int'(mv.move_row) < N) && (int'(mv.move_col) < N);
        mv_idx     = CW'(int'(mv.move_row) * N + int'(mv.move_col));
        last_line  = (scan_idx == LW'(L - 1));
        board_full = (move_cnt == NW'(N * N));
        case (state)
            IDLE: begin
                if (mv.move_valid) begin
                    // mv_idx may alias a real cell when out of range, so range gates the lookup
                    if (in_range && !cell_valid[mv_idx]) begin
                        accept   = 1'b1;
                        state_nx = CHECK;
                    end else begin
                        reject   = 1'b1;
                    end
                end
            end
            CHECK: begin
                if (line_hit)
                    state_nx = DONE;
                else if (last_line)
                    state_nx = board_full ? DONE : IDLE;
            end
            DONE:    state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset || new_game) begin
            cell_valid  <= '0;
            cell_symbol <= '0;
            turn        <= SYM_X;
            game_over   <= 1'b0;
            winner      <= 1'b0;
            draw        <= 1'b0;
            move_cnt    <= '0;
            scan_idx    <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            ack_q <= accept;
            err_q <= reject;
            if (accept) begin
                cell_valid[mv_idx]  <= 1'b1;
                cell_symbol[mv_idx] <= turn;
                turn                <= ~turn;
                move_cnt            <= move_cnt + 1'b1;
                scan_idx            <= '0;
            end
            if (state == CHECK) begin
                scan_idx <= scan_idx + 1'b1;
                if (line_hit) begin
                    game_over <= 1'b1;
                    winner    <= line_sym;
                end else if (last_line && board_full) begin
                    game_over <= 1'b1;
                    draw      <= 1'b1;
                end
            end
        end
    end

    assign mv.move_ready = (state == IDLE);
    assign mv.move_ack   = ack_q;
    assign mv.move_err   = err_q;

endmodule

// File: tb/tb_tboard_grid.sv
// Bench for tboard_grid: a 3x3 and a 4x4 board driven from one move port,
// checked against hand tables and a board-array reference model.
module tb_tboard_grid;

    logic       clk = 1'b0;
    logic       reset, new_game, drv_valid, sel;
    logic [1:0] drv_row, drv_col;

    always #5 clk = ~clk;

    tboard_grid_if #(.N(3)) if3 ();
    tboard_grid_if #(.N(4)) if4 ();

    assign if3.move_valid = drv_valid & ~sel;
    assign if3.move_row   = drv_row;
    assign if3.move_col   = drv_col;
    assign if4.move_valid = drv_valid & sel;
    assign if4.move_row   = drv_row;
    assign if4.move_col   = drv_col;

    logic [8:0]  cv3, cs3;
    logic [15:0] cv4, cs4;
    logic        turn3, go3, win3, draw3, turn4, go4, win4, draw4;

    tboard_grid #(.N(3)) dut3 (
        .clk(clk), .reset(reset), .new_game(new_game), .mv(if3),
        .cell_valid(cv3), .cell_symbol(cs3), .turn(turn3),
        .game_over(go3), .winner(win3), .draw(draw3)
    );

    tboard_grid #(.N(4)) dut4 (
        .clk(clk), .reset(reset), .new_game(new_game), .mv(if4),
        .cell_valid(cv4), .cell_symbol(cs4), .turn(turn4),
        .game_over(go4), .winner(win4), .draw(draw4)
    );

    logic        s_ready, s_ack, s_err, s_turn, s_go, s_win, s_draw;
    logic [15:0] s_cv, s_cs;
    assign s_ready = sel ? if4.move_ready : if3.move_ready;
    assign s_ack   = sel ? if4.move_ack   : if3.move_ack;
    assign s_err   = sel ? if4.move_err   : if3.move_err;
    assign s_turn  = sel ? turn4 : turn3;
    assign s_go    = sel ? go4   : go3;
    assign s_win   = sel ? win4  : win3;
    assign s_draw  = sel ? draw4 : draw3;
    assign s_cv    = sel ? cv4 : {7'b0, cv3};
    assign s_cs    = sel ? cs4 : {7'b0, cs3};

    int vec_cnt = 0;
    int miss    = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic clear_board();
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
    endtask

    // outcome: 0 back to IDLE, 1 win, 2 draw, 3 no response, 4 rejected
    task automatic apply_move(input int r, input int c, output int outcome, output int lat,
                              output logic turn_after);
        int budget;
        int lines;
        lines      = sel ? 10 : 8;
        outcome    = 3;
        lat        = 0;
        turn_after = 1'b0;
        budget     = 0;
        while (!s_ready && budget < 40) begin
            @(negedge clk);
            budget++;
        end
        if (!s_ready) begin
            check("ready_wait", 0, 1);
            return;
        end
        drv_valid = 1'b1;
        drv_row   = r[1:0];
        drv_col   = c[1:0];
        @(negedge clk);
        drv_valid  = 1'b0;
        turn_after = s_turn;
        check("ack_err_exclusive", {31'b0, s_ack & s_err}, 0);
        if (s_err) begin
            outcome = 4;
            @(negedge clk);
            check("err_pulse_len", {31'b0, s_err}, 0);
            return;
        end
        if (!s_ack) return;
        for (int j = 1; j <= lines + 2; j++) begin
            if (!s_ready && !s_go) begin
                drv_valid = 1'($urandom_range(0, 1));
                drv_row   = 2'($urandom);
                drv_col   = 2'($urandom);
            end
            @(negedge clk);
            drv_valid = 1'b0;
            check("quiet_during_scan", {30'b0, s_ack, s_err}, 0);
            if (s_go) begin
                outcome = s_draw ? 2 : 1;
                lat     = j;
                break;
            end
            if (s_ready) begin
                outcome = 0;
                lat     = j;
                break;
            end
        end
    endtask

    typedef struct {
        bit          sel;
        bit          clr;
        int          r;
        int          c;
        int          outcome;
        int          lat;
        bit          turn;
        logic [15:0] cv;
        bit          wsym;
    } vec_t;

    vec_t tab[24];

    // Reference model: plain board array, -1 empty, 0 X, 1 O
    int b[3][3];

    function automatic int first_win(output int wsym);
        wsym = 0;
        for (int i = 0; i < 3; i++)
            if (b[i][0] != -1 && b[i][0] == b[i][1] && b[i][1] == b[i][2]) begin
                wsym = b[i][0];
                return i;
            end
        for (int i = 0; i < 3; i++)
            if (b[0][i] != -1 && b[0][i] == b[1][i] && b[1][i] == b[2][i]) begin
                wsym = b[0][i];
                return 3 + i;
            end
        if (b[0][0] != -1 && b[0][0] == b[1][1] && b[1][1] == b[2][2]) begin
            wsym = b[0][0];
            return 6;
        end
        if (b[0][2] != -1 && b[0][2] == b[1][1] && b[1][1] == b[2][0]) begin
            wsym = b[0][2];
            return 7;
        end
        return -1;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   oc, lt, ws, w, mturn, mcnt, r, c, exp_oc, exp_lat;
        bit   legal, stale;
        logic t;
        logic [8:0] mcv, mcs;

        tab[0]  = '{0, 1, 0, 0, 0, 8, 1, 16'h0001, 0};
        tab[1]  = '{0, 0, 1, 0, 0, 8, 0, 16'h0009, 0};
        tab[2]  = '{0, 0, 0, 1, 0, 8, 1, 16'h000B, 0};
        tab[3]  = '{0, 0, 1, 1, 0, 8, 0, 16'h001B, 0};
        tab[4]  = '{0, 0, 0, 2, 1, 1, 1, 16'h001F, 0};
        tab[5]  = '{0, 1, 1, 1, 0, 8, 1, 16'h0010, 0};
        tab[6]  = '{0, 0, 1, 1, 4, 0, 1, 16'h0010, 0};
        tab[7]  = '{0, 0, 3, 0, 4, 0, 1, 16'h0010, 0};
        tab[8]  = '{0, 1, 0, 0, 0, 8, 1, 16'h0001, 0};
        tab[9]  = '{0, 0, 0, 1, 0, 8, 0, 16'h0003, 0};
        tab[10] = '{0, 0, 0, 2, 0, 8, 1, 16'h0007, 0};
        tab[11] = '{0, 0, 1, 1, 0, 8, 0, 16'h0017, 0};
        tab[12] = '{0, 0, 1, 0, 0, 8, 1, 16'h001F, 0};
        tab[13] = '{0, 0, 1, 2, 0, 8, 0, 16'h003F, 0};
        tab[14] = '{0, 0, 2, 1, 0, 8, 1, 16'h00BF, 0};
        tab[15] = '{0, 0, 2, 0, 0, 8, 0, 16'h00FF, 0};
        tab[16] = '{0, 0, 2, 2, 2, 8, 1, 16'h01FF, 0};
        tab[17] = '{1, 1, 0, 3, 0, 10, 1, 16'h0008, 0};
        tab[18] = '{1, 0, 3, 1, 0, 10, 0, 16'h2008, 0};
        tab[19] = '{1, 0, 1, 2, 0, 10, 1, 16'h2048, 0};
        tab[20] = '{1, 0, 3, 2, 0, 10, 0, 16'h6048, 0};
        tab[21] = '{1, 0, 2, 1, 0, 10, 1, 16'h6248, 0};
        tab[22] = '{1, 0, 3, 3, 0, 10, 0, 16'hE248, 0};
        tab[23] = '{1, 0, 3, 0, 1, 10, 1, 16'hF248, 0};

        reset     = 1'b0;
        new_game  = 1'b0;
        sel       = 1'b0;
        drv_valid = 1'b0;
        drv_row   = '0;
        drv_col   = '0;

        // Reset held two cycles with random move traffic
        repeat (2) begin
            drv_valid = 1'($urandom_range(0, 1));
            drv_row   = 2'($urandom);
            drv_col   = 2'($urandom);
            @(negedge clk);
        end
        check("rst_cv3", {23'b0, cv3}, 0);
        check("rst_cs3", {23'b0, cs3}, 0);
        check("rst_flags3", {26'b0, turn3, go3, win3, draw3, if3.move_ack, if3.move_err}, 0);
        check("rst_cv4", {16'b0, cv4}, 0);
        check("rst_flags4", {26'b0, turn4, go4, win4, draw4, if4.move_ack, if4.move_err}, 0);
        drv_valid = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        check("rst_ready3", {31'b0, if3.move_ready}, 1);
        check("rst_ready4", {31'b0, if4.move_ready}, 1);

        for (int i = 0; i < 24; i++) begin
            sel = tab[i].sel;
            if (tab[i].clr) clear_board();
            apply_move(tab[i].r, tab[i].c, oc, lt, t);
            check($sformatf("t%0d_outcome", i), oc, tab[i].outcome);
            if (tab[i].outcome != 4)
                check($sformatf("t%0d_latency", i), lt, tab[i].lat);
            check($sformatf("t%0d_turn", i), {31'b0, t}, {31'b0, tab[i].turn});
            check($sformatf("t%0d_cell_valid", i), {16'b0, s_cv}, {16'b0, tab[i].cv});
            if (tab[i].outcome == 1) begin
                check($sformatf("t%0d_winner", i), {31'b0, s_win}, {31'b0, tab[i].wsym});
                repeat (3) @(negedge clk);
                check($sformatf("t%0d_done_ready", i), {31'b0, s_ready}, 0);
                check($sformatf("t%0d_done_status", i), {30'b0, s_go, s_draw}, 32'h2);
            end
            if (tab[i].outcome == 2)
                check($sformatf("t%0d_draw", i), {30'b0, s_go, s_draw}, 32'h3);
            if (i == 6)
                check("t6_sym4", {31'b0, s_cs[4]}, 0);
        end

        // Clear mid-scan of a move that would win on the anti-diagonal
        sel = 1'b0;
        clear_board();
        apply_move(0, 2, oc, lt, t);
        check("mid_m0", oc, 0);
        apply_move(0, 0, oc, lt, t);
        check("mid_m1", oc, 0);
        apply_move(1, 1, oc, lt, t);
        check("mid_m2", oc, 0);
        apply_move(0, 1, oc, lt, t);
        check("mid_m3", oc, 0);
        drv_valid = 1'b1;
        drv_row   = 2'd2;
        drv_col   = 2'd0;
        @(negedge clk);
        drv_valid = 1'b0;
        check("mid_ack", {31'b0, s_ack}, 1);
        repeat (3) @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        check("mid_ready", {31'b0, s_ready}, 1);
        check("mid_state", {30'b0, s_turn, s_go}, 0);
        check("mid_cells", {7'b0, cv3, 7'b0, cs3}, 0);
        stale = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (s_go || !s_ready) stale = 1'b1;
        end
        check("mid_no_stale", {31'b0, stale}, 0);

        // Random games against the board-array model
        for (int g = 0; g < 8; g++) begin
            sel = 1'b0;
            clear_board();
            for (int rr = 0; rr < 3; rr++)
                for (int cc = 0; cc < 3; cc++)
                    b[rr][cc] = -1;
            mturn = 0;
            mcnt  = 0;
            for (int m = 0; m < 14; m++) begin
                r = int'($urandom_range(0, 3));
                c = int'($urandom_range(0, 3));
                legal = 1'b0;
                if (r < 3 && c < 3) legal = (b[r][c] == -1);
                ws = 0;
                if (legal) begin
                    b[r][c] = mturn;
                    mturn   = 1 - mturn;
                    mcnt++;
                    w = first_win(ws);
                    if (w >= 0) begin
                        exp_oc  = 1;
                        exp_lat = w + 1;
                    end else begin
                        exp_oc  = (mcnt == 9) ? 2 : 0;
                        exp_lat = 8;
                    end
                end else begin
                    exp_oc  = 4;
                    exp_lat = 0;
                end
                apply_move(r, c, oc, lt, t);
                mcv = '0;
                mcs = '0;
                for (int rr = 0; rr < 3; rr++)
                    for (int cc = 0; cc < 3; cc++)
                        if (b[rr][cc] != -1) begin
                            mcv[rr*3+cc] = 1'b1;
                            mcs[rr*3+cc] = (b[rr][cc] == 1);
                        end
                check($sformatf("g%0d_m%0d_outcome", g, m), oc, exp_oc);
                if (exp_oc != 4)
                    check($sformatf("g%0d_m%0d_latency", g, m), lt, exp_lat);
                check($sformatf("g%0d_m%0d_turn", g, m), {31'b0, t}, mturn);
                check($sformatf("g%0d_m%0d_cells", g, m), {7'b0, cv3, 7'b0, cs3 & cv3},
                      {7'b0, mcv, 7'b0, mcs});
                if (exp_oc == 1)
                    check($sformatf("g%0d_m%0d_winner", g, m), {31'b0, s_win}, ws);
                if (exp_oc == 1 || exp_oc == 2) break;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss);
        $finish;
    end

endmodule
